// File: rtl/mosby_defs.sv
// Shared definitions for the cache refill path: FSM encoding and the
// default line geometry / timeout used by both the cache and its refill
// controller.
package mosby_defs;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DEF_LINE_BYTES = 4;
    localparam int DEF_TIMEOUT    = 64;

endpackage

// File: rtl/cache_line_fill.sv
// Miss-refill controller: on a cache miss, fetches the whole line from
// memory one byte per handshake, critical byte first with the offset
// wrapping inside the line, and writes each byte into the cache with a
// one-cycle strobe. Ends with a done pulse, flagged as an error when a
// beat waited too long for mem_ack.
module cache_line_fill
    import mosby_defs::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              fill_busy,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_done,
    output logic              fill_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_BYTES - 1);
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    logic [1:0]              state_q;
    logic [ADDR_W-1:OFF_W]   base_q;
    logic [OFF_W-1:0]        start_q;
    logic [OFF_W-1:0]        beat_q;
    logic [7:0]              tcnt_q;
    logic                    err_q;
    logic [DATA_W-1:0]       data_q;

    logic [OFF_W-1:0]        offset;
    logic [ADDR_W-1:0]       cur_addr;
    logic [7:0]              tcnt_inc;

    // The offset is computed at OFF_W bits so it wraps inside the line and
    // never carries into the base.
    assign offset   = start_q + beat_q;
    assign cur_addr = {base_q, offset};
    assign tcnt_inc = tcnt_q + 8'd1;

    // Control path: state, address registers, beat and timeout counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            start_q <= '0;
            beat_q  <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_req) begin
                        base_q  <= miss_addr[ADDR_W-1:OFF_W];
                        start_q <= miss_addr[OFF_W-1:0];
                        beat_q  <= '0;
                        tcnt_q  <= '0;
                        err_q   <= 1'b0;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An ack in the cycle the counter would expire still wins.
                    if (mem_ack) begin
                        state_q <= ST_WRITE;
                    end else if (tcnt_inc == TO_LIM) begin
                        tcnt_q  <= tcnt_inc;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        tcnt_q  <= tcnt_inc;
                    end
                end
                ST_WRITE: begin
                    if (beat_q == LAST_BEAT) begin
                        state_q <= ST_DONE;
                    end else begin
                        beat_q  <= beat_q + 1'b1;
                        tcnt_q  <= '0;
                        state_q <= ST_REQ;
                    end
                end
                default: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Data path: capture the returned byte; outputs are gated, so no reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_REQ && mem_ack) begin
            data_q <= mem_rdata;
        end
    end

    assign fill_busy = (state_q != ST_IDLE);
    assign mem_req   = (state_q == ST_REQ);
    assign mem_addr  = mem_req ? cur_addr : '0;
    assign fill_we   = (state_q == ST_WRITE);
    assign fill_addr = fill_we ? cur_addr : '0;
    assign fill_data = fill_we ? data_q : '0;
    assign fill_done = (state_q == ST_DONE);
    assign fill_err  = fill_done & err_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill: a table of miss scenarios with
// hand-computed address orders and completion cycles, driven against a
// small memory responder, plus a hand-written reset-mid-fill sequence.
module tb_cache_line_fill;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_req;
    logic [15:0] miss_addr;
    logic        fill_busy;
    logic        fill_we;
    logic [15:0] fill_addr;
    logic [7:0]  fill_data;
    logic        fill_done;
    logic        fill_err;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    cache_line_fill #(
        .ADDR_W(16), .DATA_W(8), .LINE_BYTES(4), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .fill_busy(fill_busy), .fill_we(fill_we), .fill_addr(fill_addr),
        .fill_data(fill_data), .fill_done(fill_done), .fill_err(fill_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Memory responder: data is a fixed function of the requested address.
    assign mem_rdata = mem_byte(mem_addr);

    typedef struct {
        logic [15:0]      addr;
        int               wait_cyc;
        int               ack_beats;
        logic [3:0][15:0] ea;
        int               done_cyc;
        logic             err;
        int               writes;
        bit               poke;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [15:0] a, input int w, input int ab,
                                input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] a2, input logic [15:0] a3,
                                input int dc, input logic e, input int wr,
                                input bit pk);
        vec_t v;
        v.addr = a; v.wait_cyc = w; v.ack_beats = ab;
        v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
        v.done_cyc = dc; v.err = e; v.writes = wr; v.poke = pk;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int cyc, beat, waited, writes, reqc;
        bit done;
        miss_addr = v.addr;
        miss_req  = 1'b1;
        @(posedge clk); #1;
        miss_req  = 1'b0;
        miss_addr = '0;
        cyc = 1; beat = 0; waited = 0; writes = 0; reqc = 0; done = 0;
        while (!done && cyc < 200) begin
            check({nm, " busy"}, 32'(fill_busy), 32'd1);
            if (v.poke && cyc == 3) begin
                miss_req  = 1'b1;
                miss_addr = 16'h0BAD;
            end else begin
                miss_req  = 1'b0;
                miss_addr = '0;
            end
            mem_ack = 1'b0;
            if (fill_done) begin
                check({nm, " done_cycle"}, 32'(cyc), 32'(v.done_cyc));
                check({nm, " err"}, 32'(fill_err), 32'(v.err));
                check({nm, " writes"}, 32'(writes), 32'(v.writes));
                check({nm, " req_in_done"}, 32'(mem_req), 32'd0);
                if (v.err) check({nm, " timeout_req_cycles"}, 32'(reqc), 32'(TO));
                done = 1;
            end else if (fill_we) begin
                check({nm, " fill_addr"}, 32'(fill_addr), 32'(v.ea[beat[1:0]]));
                check({nm, " fill_data"}, 32'(fill_data), 32'(mem_byte(v.ea[beat[1:0]])));
                writes++; beat++; waited = 0; reqc = 0;
            end else if (mem_req) begin
                check({nm, " mem_addr"}, 32'(mem_addr), 32'(v.ea[beat[1:0]]));
                reqc++;
                if (beat < v.ack_beats && waited == v.wait_cyc) mem_ack = 1'b1;
                else waited++;
            end else begin
                check({nm, " unexpected_idle"}, 32'(fill_busy), 32'd1);
                done = 1;
            end
            if (!done) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        mem_ack  = 1'b0;
        miss_req = 1'b0;
        if (!done) check({nm, " cycle_budget"}, 32'(cyc), 32'(v.done_cyc));
        @(posedge clk); #1;
        check({nm, " idle_busy"}, 32'(fill_busy), 32'd0);
        check({nm, " idle_done"}, 32'(fill_done), 32'd0);
        check({nm, " idle_req"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        int wb;
        bit found;
        vecs[0] = mk(16'h1200, 0, 4, 16'h1200, 16'h1201, 16'h1202, 16'h1203, 9, 1'b0, 4, 0);
        vecs[1] = mk(16'h12A6, 0, 4, 16'h12A6, 16'h12A7, 16'h12A4, 16'h12A5, 9, 1'b0, 4, 0);
        vecs[2] = mk(16'h3451, 3, 4, 16'h3451, 16'h3452, 16'h3453, 16'h3450, 21, 1'b0, 4, 0);
        vecs[3] = mk(16'h5002, 0, 1, 16'h5002, 16'h5003, 16'h5000, 16'h5001, 11, 1'b1, 1, 0);
        vecs[4] = mk(16'hFFFF, 0, 4, 16'hFFFF, 16'hFFFC, 16'hFFFD, 16'hFFFE, 9, 1'b0, 4, 1);
        vecs[5] = mk(16'h7777, 7, 4, 16'h7777, 16'h7774, 16'h7775, 16'h7776, 37, 1'b0, 4, 0);

        rst = 1'b1; miss_req = 1'b0; miss_addr = '0; mem_ack = 1'b0;
        #12;
        check("reset busy", 32'(fill_busy), 32'd0);
        check("reset we", 32'(fill_we), 32'd0);
        check("reset done", 32'(fill_done), 32'd0);
        check("reset req", 32'(mem_req), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted during the beat-2 write abandons the fill.
        miss_addr = 16'h2340; miss_req = 1'b1;
        @(posedge clk); #1;
        miss_req = 1'b0;
        wb = 0; found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            mem_ack = mem_req;
            if (fill_we) begin
                if (wb == 2) found = 1;
                else wb++;
            end
            if (!found) begin @(posedge clk); #1; end
        end
        mem_ack = 1'b0;
        check("rstmid reached_beat2", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid we", 32'(fill_we), 32'd0);
        check("rstmid busy", 32'(fill_busy), 32'd0);
        check("rstmid addr", 32'(fill_addr), 32'd0);
        check("rstmid data", 32'(fill_data), 32'd0);
        check("rstmid req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("rstmid no_done", 32'(fill_done), 32'd0);
            check("rstmid no_we", 32'(fill_we), 32'd0);
        end
        run_vec(vecs[0], "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Miss-refill controller between the cache and external memory.
- On a cache miss it fetches the whole line from memory, one byte per handshake, critical byte first with wrap-around order.
- Each returned byte is written into the cache through a one-cycle write strobe, and the controller signals completion or timeout.
- Downstream of the cache: it consumes the cache's miss and produces the line data that turns the next lookup into a hit.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 8, data width in bits (one beat).
- LINE_BYTES, 4, bytes per cache line; power of two, 2..16.
- TIMEOUT, 64, maximum cycles spent waiting for mem_ack on one beat before the fill is aborted; 1..255.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_req  in  1  cache reports a miss; sampled only in IDLE.
- miss_addr  in  ADDR_W  address that missed; sampled with miss_req.
- fill_busy  out  1  high from the cycle after miss acceptance until the DONE cycle inclusive.
- fill_we  out  1  one-cycle cache write strobe.
- fill_addr  out  ADDR_W  cache write address; valid when fill_we is high.
- fill_data  out  DATA_W  cache write data; valid when fill_we is high.
- fill_done  out  1  one-cycle pulse at the end of a fill.
- fill_err  out  1  one-cycle pulse, coincident with fill_done, when the fill was aborted by timeout.
- mem_req  out  1  memory read request; held high until mem_ack.
- mem_addr  out  ADDR_W  memory read address; stable while mem_req is high.
- mem_ack  in  1  memory has valid data on mem_rdata this cycle.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:

Reset:
- Clock is clk. Reset is rst: asynchronous and active-high.
- Reset forces state IDLE and clears all outputs, the beat counter, the timeout counter, and the base/offset registers.
- Reset asserted mid-fill abandons the fill immediately: no further fill_we, and no fill_done.

Registered address state:
- base = miss_addr with its low log2(LINE_BYTES) bits cleared.
- start = low log2(LINE_BYTES) bits of miss_addr.
- beat = 0..LINE_BYTES-1.
- Current byte address = base | ((start + beat) mod LINE_BYTES). The offset wraps inside the line, and base never changes during a fill.

FSM states: IDLE, REQ, WRITE, DONE.
- IDLE:
  - Outputs low.
  - If miss_req = 1: latch base and start, set beat = 0 and timeout counter = 0, go to REQ.
  - If miss_req = 0: stay in IDLE.
- REQ:
  - mem_req = 1; mem_addr = current byte address; fill_busy = 1.
  - If mem_ack = 1: capture mem_rdata into the data register, go to WRITE. mem_req drops in the WRITE cycle.
  - Otherwise, increment the timeout counter. When it reaches TIMEOUT, drop mem_req, set the error flag, and go to DONE.
- WRITE:
  - fill_we = 1 for exactly one cycle; fill_addr = current byte address; fill_data = captured byte.
  - If beat = LINE_BYTES-1: go to DONE.
  - Otherwise: beat++, timeout counter = 0, go to REQ.
- DONE:
  - fill_done = 1 for one cycle; fill_err = error flag; fill_busy = 1.
  - Next cycle: clear the error flag and go to IDLE.

Timing and boundary rules:
- Latency: minimum per beat is 2 cycles (REQ with immediate ack, then WRITE). A full line with zero-wait memory takes 1 + 2*LINE_BYTES cycles from miss acceptance to the fill_done cycle.
- miss_req while not in IDLE is ignored and not queued; the cache re-raises it after fill_done.
- mem_ack outside REQ is ignored.
- mem_ack arriving in the same cycle the timeout counter would reach TIMEOUT counts as success (ack wins).
- A timeout on beat k leaves beats 0..k-1 written. The cache must invalidate the line when fill_err = 1.
- Address 16'hFFFF with LINE_BYTES = 4 gives base 16'hFFFC; no carry beyond ADDR_W is ever produced.

Decomposition:
- Shared package or include file `mosby_defs`:
  - FSM state encoding: 2-bit localparams ST_IDLE = 0, ST_REQ = 1, ST_WRITE = 2, ST_DONE = 3.
  - Default LINE_BYTES and TIMEOUT constants, reused by the cache.
- No sub-module. The FSM, beat counter, timeout counter, and address generation sit in one module; address generation is a continuous assignment.

Test Plan:
1. Aligned miss, zero-wait memory: miss_addr = 16'h1200, mem_ack is asserted every REQ cycle.
   -> fill_we at addresses 1200, 1201, 1202, 1203 with the data returned for each.
   -> fill_done 9 cycles after acceptance; fill_err = 0.
2. Critical byte first: miss_addr = 16'h12A6.
   -> mem_addr sequence is 12A6, 12A7, 12A4, 12A5; fill_addr follows the same order.
3. Wait states: mem_ack delayed 3 cycles on every beat.
   -> mem_req and mem_addr stay stable while waiting.
   -> exactly 4 fill_we pulses; fill_done at cycle 1 + 4*(3+2) = 21.
4. Timeout: TIMEOUT = 8, memory acks beat 0 only, then never again.
   -> one fill_we.
   -> mem_req high for 8 cycles on beat 1, then drops.
   -> fill_done and fill_err pulse together; return to IDLE.
5. Busy and top-of-memory: second miss_req mid-fill is ignored; later, miss_addr = 16'hFFFF.
   -> addresses FFFF, FFFC, FFFD, FFFE.
6. Reset mid-fill: assert rst during beat 2 WRITE.
   -> all outputs 0 asynchronously; no fill_done.
   -> after release, a new miss starts cleanly at beat 0.
